// File: rtl/rggen_lock_key_controller.sv
// Two-key unlock sequencer guarding rwl register fields (KEY0 then KEY1 within an arm window).
// Optional idle auto-relock while unlocked is enabled by defining RGGEN_LOCK_IDLE_TIMEOUT_EN.
module rggen_lock_key_controller #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] KEY0         = 32'h0000_C0DE,
  parameter logic [31:0] KEY1         = 32'h0000_FACE,
  parameter int          ARM_WINDOW   = 16,
  parameter int          IDLE_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_command_valid,
  input  logic             i_select,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_write_data,
  input  logic [WIDTH-1:0] i_write_mask,
  input  logic             i_activity,
  input  logic             i_force_lock,
  output logic             o_lock,
  output logic [WIDTH-1:0] o_read_data,
  output logic             o_key_error,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_ARMED    = 2'b01,
    ST_UNLOCKED = 2'b10,
    ST_INVALID  = 2'b11
  } state_t;

  // Expiry fires on the edge that completes the N-th idle cycle after entry.
  localparam logic [15:0] ARM_LIMIT  = 16'(ARM_WINDOW - 1);
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_count;
  logic [15:0] w_next_count;
  logic        r_lock;
  logic        r_key_error;
  logic        r_timeout;
  logic        w_key_error;
  logic        w_timeout;
  logic        w_count_clear;
  logic        w_key_write;
  logic        w_key0_ok;
  logic        w_key1_ok;

  assign w_key_write = i_command_valid & i_select & i_write;
  assign w_key0_ok   = w_key_write & (&i_write_mask) & (i_write_data == KEY0[WIDTH-1:0]);
  assign w_key1_ok   = w_key_write & (&i_write_mask) & (i_write_data == KEY1[WIDTH-1:0]);

`ifndef RGGEN_LOCK_IDLE_TIMEOUT_EN
  logic w_unused_activity;
  assign w_unused_activity = i_activity;
`endif

  always_comb begin
    w_next_state  = r_state;
    w_key_error   = 1'b0;
    w_timeout     = 1'b0;
    w_count_clear = 1'b0;
    if (i_force_lock) begin
      w_next_state = ST_LOCKED;
    end else begin
      case (r_state)
        ST_LOCKED: begin
          if (w_key_write) begin
            if (w_key0_ok) w_next_state = ST_ARMED;
            else           w_key_error  = 1'b1;
          end
        end
        ST_ARMED: begin
          // A key write always wins over a window expiring in the same cycle.
          if (w_key_write) begin
            if (w_key1_ok) begin
              w_next_state = ST_UNLOCKED;
            end else begin
              w_next_state = ST_LOCKED;
              w_key_error  = 1'b1;
            end
          end else if (r_count >= ARM_LIMIT) begin
            w_next_state = ST_LOCKED;
            w_timeout    = 1'b1;
          end
        end
        ST_UNLOCKED: begin
          if (w_key_write) begin
            w_next_state = ST_LOCKED;
`ifdef RGGEN_LOCK_IDLE_TIMEOUT_EN
          end else if (i_activity) begin
            w_count_clear = 1'b1;
          end else if (r_count >= IDLE_LIMIT) begin
            w_next_state = ST_LOCKED;
            w_timeout    = 1'b1;
`endif
          end
        end
        default: w_next_state = ST_LOCKED;
      endcase
    end
  end

  always_comb begin
    w_next_count = r_count;
    if ((w_next_state != r_state) || w_count_clear) w_next_count = '0;
    else if (r_count != 16'hFFFF)                   w_next_count = r_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOCKED;
      r_count     <= '0;
      r_lock      <= 1'b1;
      r_key_error <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      r_lock      <= (w_next_state != ST_UNLOCKED);
      r_key_error <= w_key_error;
      r_timeout   <= w_timeout;
    end
  end

  always_comb begin
    o_read_data      = '0;
    o_read_data[1:0] = r_state;
  end

  assign o_lock      = r_lock;
  assign o_key_error = r_key_error;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rggen_lock_key_controller.sv
// Scenario bench for rggen_lock_key_controller; expectations depend on RGGEN_LOCK_IDLE_TIMEOUT_EN.
module tb_rggen_lock_key_controller;

  localparam int          WIDTH = 32;
  localparam logic [31:0] KEY0  = 32'h0000_C0DE;
  localparam logic [31:0] KEY1  = 32'h0000_FACE;

  logic             clk;
  logic             rst;
  logic             i_command_valid;
  logic             i_select;
  logic             i_write;
  logic [WIDTH-1:0] i_write_data;
  logic [WIDTH-1:0] i_write_mask;
  logic             i_activity;
  logic             i_force_lock;
  logic             o_lock;
  logic [WIDTH-1:0] o_read_data;
  logic             o_key_error;
  logic             o_timeout;

  logic [34:0] exp_q[$];
  logic [34:0] exp_v;
  logic [34:0] obs_v;
  int          n_checks;
  int          n_pass;

  rggen_lock_key_controller #(
    .WIDTH(WIDTH), .KEY0(KEY0), .KEY1(KEY1), .ARM_WINDOW(16), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_command_valid(i_command_valid), .i_select(i_select), .i_write(i_write),
    .i_write_data(i_write_data), .i_write_mask(i_write_mask),
    .i_activity(i_activity), .i_force_lock(i_force_lock),
    .o_lock(o_lock), .o_read_data(o_read_data),
    .o_key_error(o_key_error), .o_timeout(o_timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {lock, key_error, timeout, read_data}
  function automatic logic [34:0] ev(input logic l, input logic e, input logic t,
                                     input logic [1:0] s);
    return {l, e, t, 30'd0, s};
  endfunction

  task automatic drive(input logic kw, input logic [31:0] data, input logic [31:0] mask,
                       input logic act, input logic frc, input logic rd);
    i_command_valid = kw | rd;
    i_select        = kw | rd;
    i_write         = kw;
    i_write_data    = data;
    i_write_mask    = mask;
    i_activity      = act;
    i_force_lock    = frc;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [31:0] data);
    drive(1'b1, data, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key(KEY0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0));
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_unlock();
    do_reset();
    // KEY0, KEY1, read, idle, voluntary relock write
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1)); end
        1: begin key(KEY1); exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2)); end
        2: begin drive(1'b0, KEY0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
                 exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2)); end
        3: begin idle(); exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2)); end
        default: begin key(32'h5555_0000); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
      endcase
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL unlock[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_bad_key();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin key(32'h0000_1234); exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 2'd0)); end
        1: begin idle(); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
        2: begin drive(1'b1, KEY0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
                 exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 2'd0)); end
        3: begin key(KEY0); i_select = 1'b0; exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
        default: begin key(KEY0); i_command_valid = 1'b0;
                       exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
      endcase
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL bad_key[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  // Window expiry, then a late KEY1; second pass writes KEY1 on the expiring cycle.
  task automatic test_arm_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 18; i++) begin
        if (i == 0) begin
          key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1));
        end else if (i < 16) begin
          idle(); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1));
        end else if (i == 16 && pass == 0) begin
          idle(); exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 2'd0));
        end else if (i == 16) begin
          key(KEY1); exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2));
        end else if (pass == 0) begin
          key(KEY1); exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 2'd0));
        end else begin
          idle(); exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2));
        end
        tick();
        obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL arm_timeout[%0d.%0d]: got %h want %h", pass, i, obs_v, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_idle_timeout();
    do_reset();
    key(KEY0); tick();
    key(KEY1); tick();
    for (int k = 1; k <= 30; k++) begin
      drive(1'b0, 32'd0, 32'd0, (k == 5), 1'b0, 1'b0);
`ifdef RGGEN_LOCK_IDLE_TIMEOUT_EN
      if (k < 13)       exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2));
      else if (k == 13) exp_q.push_back(ev(1'b1, 1'b0, 1'b1, 2'd0));
      else              exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0));
`else
      exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2));
`endif
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL idle_timeout[%0d]: got %h want %h", k, obs_v, exp_v);
      else n_pass++;
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0));
    tick();
    obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL idle_force: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_force();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1)); end
        1: begin key(KEY1); i_force_lock = 1'b1; exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
        2: begin key(KEY1); exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 2'd0)); end
        3: begin key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1)); end
        4: begin key(KEY1); exp_q.push_back(ev(0, 1'b0, 1'b0, 2'd2)); end
        5: begin idle(); i_force_lock = 1'b1; exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
        default: begin key(32'h0BAD_0BAD); i_force_lock = 1'b1;
                       exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
      endcase
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL force[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rst = 1'b0;
      case (i)
        0: begin key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1)); end
        1: begin rst = 1'b1; idle(); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
        2: begin key(KEY1); exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 2'd0)); end
        3: begin key(KEY0); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd1)); end
        4: begin key(KEY1); exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 2'd2)); end
        default: begin rst = 1'b1; idle(); exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'd0)); end
      endcase
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset_mid[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  // Uninterrupted random key writes against a small reference sequencer.
  task automatic test_back_to_back();
    int          m_state;
    logic [31:0] data;
    logic [31:0] mask;
    logic        ok0;
    logic        ok1;
    logic        err;
    do_reset();
    m_state = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       data = KEY0;
        1:       data = KEY1;
        default: data = $urandom;
      endcase
      mask = ($urandom_range(0, 4) == 0) ? $urandom : 32'hFFFF_FFFF;
      key(data);
      i_write_mask = mask;
      ok0 = (mask == 32'hFFFF_FFFF) && (data == KEY0);
      ok1 = (mask == 32'hFFFF_FFFF) && (data == KEY1);
      err = 1'b0;
      case (m_state)
        0:       if (ok0) m_state = 1; else err = 1'b1;
        1:       if (ok1) m_state = 2; else begin m_state = 0; err = 1'b1; end
        default: m_state = 0;
      endcase
      exp_q.push_back(ev(m_state != 2, err, 1'b0, 2'(m_state)));
      tick();
      obs_v = {o_lock, o_key_error, o_timeout, o_read_data};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_unlock();
    test_bad_key();
    test_arm_timeout();
    test_idle_timeout();
    test_force();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
